// File: rtl/enigma_pkg.sv
// enigma_pkg: shared letter type, plugboard error codes and config-writer FSM states
package enigma_pkg;
  typedef logic [4:0] letter_t;
  localparam int NUM_LETTERS = 26;
  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_INVALID = 3'd1;
  localparam logic [2:0] ERR_SAME    = 3'd2;
  localparam logic [2:0] ERR_PLUGGED = 3'd3;
  localparam logic [2:0] ERR_FULL    = 3'd4;
  typedef enum logic [1:0] {IDLE, HALF, CLEAR} state_t;
  function automatic logic letter_invalid(input letter_t l);
    return l > letter_t'(NUM_LETTERS - 1);
  endfunction
endpackage

// File: rtl/plugboard_config_writer.sv
// plugboard_config_writer: pairs entered letters into an involutive 26-entry swap table
// Optional PLUGBOARD_UNPLUG_EN: in IDLE a plugged letter removes its pair instead of erroring.
module plugboard_config_writer
  import enigma_pkg::*;
#(
  parameter int MAX_PAIRS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [4:0]   in_letter,
  output logic         in_ready,
  input  logic         cfg_lock,
  input  logic         clear_req,
  output logic [129:0] map_out,
  output logic [3:0]   pair_count,
  output logic         pending,
  output logic         pair_done,
  output logic         err,
  output logic [2:0]   err_code
);
  state_t state_q, state_d;
  letter_t map_q [NUM_LETTERS];
  letter_t held_q, idx_q, li, partner;
  logic acc, clr, bad, plugged, full, hold, install, e;
  logic [2:0] ecode;
`ifdef PLUGBOARD_UNPLUG_EN
  logic unplug;
`endif

  always_ff @(posedge clk)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;

  always_comb begin
    clr      = clear_req && !cfg_lock && state_q != CLEAR;
    in_ready = state_q != CLEAR && !cfg_lock && !clear_req;
    acc      = in_valid && in_ready;
    bad      = letter_invalid(in_letter);
    li       = bad ? letter_t'(0) : in_letter;
    partner  = map_q[li];
    plugged  = !bad && partner != in_letter;
    full     = pair_count == 4'(MAX_PAIRS);
`ifdef PLUGBOARD_UNPLUG_EN
    ecode = state_q == HALF ? (bad ? ERR_INVALID : in_letter == held_q ? ERR_SAME : plugged ? ERR_PLUGGED : ERR_NONE)
                            : (bad ? ERR_INVALID : plugged ? ERR_NONE : full ? ERR_FULL : ERR_NONE);
    unplug = acc && state_q == IDLE && plugged;
`else
    ecode = state_q == HALF ? (bad ? ERR_INVALID : in_letter == held_q ? ERR_SAME : plugged ? ERR_PLUGGED : ERR_NONE)
                            : (bad ? ERR_INVALID : plugged ? ERR_PLUGGED : full ? ERR_FULL : ERR_NONE);
`endif
    e       = acc && ecode != ERR_NONE;
    hold    = acc && state_q == IDLE && ecode == ERR_NONE && !plugged;
    install = acc && state_q == HALF && ecode == ERR_NONE;
    state_d = clr ? CLEAR
            : (state_q == CLEAR && idx_q == letter_t'(NUM_LETTERS - 1)) ? IDLE
            : hold ? HALF
            : install ? IDLE
            : state_q;
  end

  always_comb pending = state_q == HALF;

  for (genvar i = 0; i < NUM_LETTERS; i++) begin : g_flat
    assign map_out[5*i +: 5] = map_q[i];
  end

  always_ff @(posedge clk)
    if (!rst_n) begin
      for (int i = 0; i < NUM_LETTERS; i++) map_q[i] <= letter_t'(i);
      pair_count <= '0;
      held_q     <= '0;
      idx_q      <= '0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      pair_done  <= 1'b0;
    end else begin
      err       <= e;
      err_code  <= e ? ecode : ERR_NONE;
      pair_done <= install;
      if (clr) begin
        pair_count <= '0;
        held_q     <= '0;
        idx_q      <= '0;
      end else if (state_q == CLEAR) begin
        map_q[idx_q] <= idx_q;
        idx_q        <= idx_q + letter_t'(1);
      end else begin
        if (hold) held_q <= in_letter;
        if (install) begin
          map_q[held_q]    <= in_letter;
          map_q[in_letter] <= held_q;
          pair_count       <= pair_count + 4'd1;
        end
`ifdef PLUGBOARD_UNPLUG_EN
        if (unplug) begin
          map_q[li]      <= li;
          map_q[partner] <= partner;
          pair_count     <= pair_count - 4'd1;
        end
`endif
      end
    end
endmodule

// File: tb/tb_plugboard_config_writer.sv
// tb_plugboard_config_writer: directed self-checking bench for plugboard_config_writer
module tb_plugboard_config_writer;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [4:0]   in_letter = '0;
  logic         in_ready;
  logic         cfg_lock = 1'b0;
  logic         clear_req = 1'b0;
  logic [129:0] map_out;
  logic [3:0]   pair_count;
  logic         pending, pair_done, err;
  logic [2:0]   err_code;
  logic [129:0] ident;
  int n_cmp = 0;
  int n_bad = 0;
  int cnt;

  plugboard_config_writer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_letter(in_letter), .in_ready(in_ready),
    .cfg_lock(cfg_lock), .clear_req(clear_req), .map_out(map_out), .pair_count(pair_count),
    .pending(pending), .pair_done(pair_done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] mp(input int i);
    return map_out[5*i +: 5];
  endfunction

  task automatic send(input logic [4:0] l);
    @(negedge clk);
    in_valid  = 1'b1;
    in_letter = l;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  task automatic do_clear(input string tag);
    @(negedge clk);
    clear_req = 1'b1;
    in_valid  = 1'b1;
    in_letter = 5'd20;
    @(negedge clk);
    clear_req = 1'b0;
    in_valid  = 1'b0;
    chk({tag, "_cnt0"}, pair_count, 0);
    chk({tag, "_pend0"}, pending, 0);
    cnt = 0;
    while (!in_ready && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk({tag, "_busy"}, cnt, 26);
    chk({tag, "_ident"}, map_out == ident, 1);
    chk({tag, "_pend"}, pending, 0);
  endtask

  initial begin
    for (int i = 0; i < 26; i++) ident[5*i +: 5] = 5'(i);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ident", map_out == ident, 1);
    chk("rst_cnt", pair_count, 0);
    chk("rst_pend", pending, 0);
    chk("rst_err", err, 0);
    chk("rst_done", pair_done, 0);
    chk("rst_ready", in_ready, 1);

    send(5'd0);
    chk("a_pend", pending, 1);
    chk("a_done", pair_done, 0);
    send(5'd1);
    chk("ab_done", pair_done, 1);
    chk("ab_err", err, 0);
    chk("ab_m0", mp(0), 1);
    chk("ab_m1", mp(1), 0);
    chk("ab_cnt", pair_count, 1);
    chk("ab_pend", pending, 0);
    @(negedge clk);
    chk("ab_pulse", pair_done, 0);

    send(5'd2);
    send(5'd2);
    chk("cc_err", err, 1);
    chk("cc_code", err_code, 2);
    chk("cc_pend", pending, 1);
    send(5'd3);
    chk("cd_done", pair_done, 1);
    chk("cd_err", err, 0);
    chk("cd_m2", mp(2), 3);
    chk("cd_m3", mp(3), 2);
    chk("cd_cnt", pair_count, 2);

    send(5'd0);
`ifdef PLUGBOARD_UNPLUG_EN
    chk("un_err", err, 0);
    chk("un_done", pair_done, 0);
    chk("un_m0", mp(0), 0);
    chk("un_m1", mp(1), 1);
    chk("un_cnt", pair_count, 1);
    send(5'd0);
    send(5'd1);
`else
    chk("pl_err", err, 1);
    chk("pl_code", err_code, 3);
    chk("pl_m0", mp(0), 1);
`endif
    chk("pl_cnt", pair_count, 2);
    chk("pl_pend", pending, 0);

    for (int p = 4; p < 20; p += 2) begin
      send(5'(p));
      send(5'(p + 1));
    end
    chk("fill_cnt", pair_count, 10);
    chk("fill_m18", mp(18), 19);
    send(5'd25);
    chk("full_err", err, 1);
    chk("full_code", err_code, 4);
    chk("full_pend", pending, 0);
    send(5'd27);
    chk("inv_err", err, 1);
    chk("inv_code", err_code, 1);
    chk("inv_cnt", pair_count, 10);
    @(negedge clk);
    chk("inv_pulse", err, 0);

    do_clear("clr1");
    send(5'd4);
    chk("e_pend", pending, 1);
    do_clear("clr2");

    send(5'd0);
    send(5'd1);
    send(5'd4);
    chk("lk_pend0", pending, 1);
    @(negedge clk);
    cfg_lock  = 1'b1;
    in_valid  = 1'b1;
    in_letter = 5'd5;
    repeat (3) @(negedge clk);
    chk("lk_ready", in_ready, 0);
    chk("lk_m4", mp(4), 4);
    chk("lk_cnt", pair_count, 1);
    chk("lk_pend", pending, 1);
    chk("lk_done", pair_done, 0);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    @(negedge clk);
    chk("lk_noclr", pair_count, 1);
    chk("lk_m0", mp(0), 1);
    cfg_lock = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ul_done", pair_done, 1);
    chk("ul_m4", mp(4), 5);
    chk("ul_m5", mp(5), 4);
    chk("ul_cnt", pair_count, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
